// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//
// Purpose:
//   Shared definitions for the VGA raster sequencer:
//     - axis_state_t : per-axis porch/sync state machine encoding
//     - default 640x480@60 timing constants (pixels / lines)
//     - constant functions that derive line and frame totals
//     - axis_next    : successor of an axis state
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Counter width used for both axes; totals must be <= 1024.
    localparam int CNT_W = 10;

    // Horizontal defaults (pixels).
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;

    // Vertical defaults (lines).
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    // Axis state machine. Order matches the raster sequence.
    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FRONT  = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BACK   = 2'd3
    } axis_state_t;

    // Positions per line (horizontal) or lines per frame (vertical).
    function automatic int h_total(input int active, input int front,
                                   input int sync,   input int back);
        return active + front + sync + back;
    endfunction

    function automatic int v_total(input int active, input int front,
                                   input int sync,   input int back);
        return active + front + sync + back;
    endfunction

    // Successor state: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
    function automatic axis_state_t axis_next(input axis_state_t s);
        axis_state_t n;
        n = ST_ACTIVE;
        case (s)
            ST_ACTIVE: n = ST_FRONT;
            ST_FRONT:  n = ST_SYNC;
            ST_SYNC:   n = ST_BACK;
            ST_BACK:   n = ST_ACTIVE;
            default:   n = ST_ACTIVE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
//
// Purpose:
//   One raster axis (horizontal or vertical). Holds the porch/sync state
//   machine, the in-state counter and the absolute position counter, and
//   decodes what the axis will present after the current edge so that the
//   parent can register its sync/active outputs in step with the position.
//
//   Every segment length parameter must be >= 1 and the sum must be <= 1024.
//
// Ports:
//   i_clk          in   clock, rising edge
//   i_rst          in   asynchronous, active-high reset
//   i_advance      in   step the axis by one position on this edge
//   o_pos          out  [9:0] current position, 0..TOTAL-1 (registered)
//   o_wrap         out  this edge moves from the last BACK position to 0
//   o_next_active  out  position after this edge lies in ST_ACTIVE
//   o_next_sync_n  out  active-low sync for the position after this edge
// ---------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int P_ACTIVE = DEF_H_ACTIVE,
    parameter int P_FRONT  = DEF_H_FRONT,
    parameter int P_SYNC   = DEF_H_SYNC,
    parameter int P_BACK   = DEF_H_BACK
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_advance,
    output logic [9:0] o_pos,
    output logic       o_wrap,
    output logic       o_next_active,
    output logic       o_next_sync_n
);

    localparam int TOTAL = h_total(P_ACTIVE, P_FRONT, P_SYNC, P_BACK);

    // Last in-state count for each segment.
    localparam logic [CNT_W-1:0] L_ACTIVE_LAST = CNT_W'(P_ACTIVE - 1);
    localparam logic [CNT_W-1:0] L_FRONT_LAST  = CNT_W'(P_FRONT - 1);
    localparam logic [CNT_W-1:0] L_SYNC_LAST   = CNT_W'(P_SYNC - 1);
    localparam logic [CNT_W-1:0] L_BACK_LAST   = CNT_W'(P_BACK - 1);
    localparam logic [CNT_W-1:0] L_POS_LAST    = CNT_W'(TOTAL - 1);

    axis_state_t      r_state;
    axis_state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] r_pos;
    logic [CNT_W-1:0] w_next_pos;
    logic [CNT_W-1:0] w_seg_last;
    logic             w_seg_done;
    logic             w_wrap;

    // State register. Reset parks the axis on the very last position so the
    // first advance after release lands on position 0 in ST_ACTIVE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_BACK;
            r_cnt   <= L_BACK_LAST;
            r_pos   <= L_POS_LAST;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_pos   <= w_next_pos;
        end
    end

    // Next-state logic. Without an advance everything holds.
    always_comb begin
        w_seg_last   = L_ACTIVE_LAST;
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_pos   = r_pos;
        w_wrap       = 1'b0;

        case (r_state)
            ST_ACTIVE: w_seg_last = L_ACTIVE_LAST;
            ST_FRONT:  w_seg_last = L_FRONT_LAST;
            ST_SYNC:   w_seg_last = L_SYNC_LAST;
            ST_BACK:   w_seg_last = L_BACK_LAST;
            default:   w_seg_last = L_ACTIVE_LAST;
        endcase

        w_seg_done = (r_cnt == w_seg_last);

        if (i_advance) begin
            if (w_seg_done) begin
                w_next_state = axis_next(r_state);
                w_next_cnt   = '0;
            end else begin
                w_next_cnt   = r_cnt + 1'b1;
            end

            // The position counter is reset from the state machine rather
            // than compared against TOTAL, so both stay in lockstep.
            if (w_seg_done && (r_state == ST_BACK)) begin
                w_next_pos = '0;
                w_wrap     = 1'b1;
            end else begin
                w_next_pos = r_pos + 1'b1;
            end
        end
    end

    assign o_pos         = r_pos;
    assign o_wrap        = w_wrap;
    assign o_next_active = (w_next_state == ST_ACTIVE);
    assign o_next_sync_n = (w_next_state != ST_SYNC);

endmodule

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//
// Purpose:
//   Raster sequencer for the 640x480 VGA output path. Owns the horizontal
//   and vertical counters and produces pixel coordinates, active-low syncs,
//   blanking and line/frame/pixel strobes. Every output is a flop; x/y and
//   the decoded outputs all describe the same pixel, so a colour source
//   that is combinational in (x, y) lines up with o_active.
//
// Configuration:
//   VGA_TIMING_PIXDIV_EN  defined   : a divide-by-2 toggle flop produces the
//                                     pixel tick (every second clock; the
//                                     first is the second edge after reset
//                                     release). Outputs hold for two clocks.
//                         undefined : every clock edge is a pixel tick.
//
// Ports:
//   i_clock        in   system clock, rising edge
//   i_reset        in   asynchronous, active-high reset
//   o_x            out  [9:0] horizontal position, 0..H_TOTAL-1
//   o_y            out  [9:0] vertical position,   0..V_TOTAL-1
//   o_active       out  pixel is inside the visible area
//   o_blank_n      out  same as o_active, for the DAC blank input
//   o_hsync        out  active-low horizontal sync
//   o_vsync        out  active-low vertical sync
//   o_line_start   out  one-clock strobe when x == 0
//   o_frame_start  out  one-clock strobe when x == 0 and y == 0
//   o_pix_en       out  one-clock strobe, a new pixel is presented
// ---------------------------------------------------------------------------
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
) (
    input  logic       i_clock,
    input  logic       i_reset,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_active,
    output logic       o_blank_n,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic       o_pix_en
);

    logic       w_tick;
    logic [9:0] w_h_pos;
    logic [9:0] w_v_pos;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic       w_h_next_active;
    logic       w_v_next_active;
    logic       w_h_next_sync_n;
    logic       w_v_next_sync_n;

    logic       r_active;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_line_start;
    logic       r_frame_start;
    logic       r_pix_en;

    // ------------------------------------------------------------------
    // Pixel tick generation
    // ------------------------------------------------------------------
`ifdef VGA_TIMING_PIXDIV_EN
    logic r_div;

    // r_div is 0 out of reset, so the first edge only toggles it and the
    // second edge is the first pixel tick.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_div <= 1'b0;
        end else begin
            r_div <= ~r_div;
        end
    end

    assign w_tick = r_div;
`else
    assign w_tick = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Axis counters: vertical steps only when the horizontal axis wraps.
    // ------------------------------------------------------------------
    vga_axis_counter #(
        .P_ACTIVE (H_ACTIVE),
        .P_FRONT  (H_FRONT),
        .P_SYNC   (H_SYNC),
        .P_BACK   (H_BACK)
    ) u_h_axis (
        .i_clk         (i_clock),
        .i_rst         (i_reset),
        .i_advance     (w_tick),
        .o_pos         (w_h_pos),
        .o_wrap        (w_h_wrap),
        .o_next_active (w_h_next_active),
        .o_next_sync_n (w_h_next_sync_n)
    );

    vga_axis_counter #(
        .P_ACTIVE (V_ACTIVE),
        .P_FRONT  (V_FRONT),
        .P_SYNC   (V_SYNC),
        .P_BACK   (V_BACK)
    ) u_v_axis (
        .i_clk         (i_clock),
        .i_rst         (i_reset),
        .i_advance     (w_h_wrap),
        .o_pos         (w_v_pos),
        .o_wrap        (w_v_wrap),
        .o_next_active (w_v_next_active),
        .o_next_sync_n (w_v_next_sync_n)
    );

    // ------------------------------------------------------------------
    // Output registers. Decodes use the axes' next state so they change on
    // the same edge as the positions. The strobes are reloaded every clock
    // so they stay one clock wide even when the pixel tick is divided.
    // The vertical axis only wraps together with the horizontal one, so
    // its wrap marks (0,0) on the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_active      <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_pix_en      <= 1'b0;
        end else begin
            r_pix_en      <= w_tick;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
            if (w_tick) begin
                r_active <= w_h_next_active && w_v_next_active;
                r_hsync  <= w_h_next_sync_n;
                r_vsync  <= w_v_next_sync_n;
            end
        end
    end

    assign o_x           = w_h_pos;
    assign o_y           = w_v_pos;
    assign o_active      = r_active;
    assign o_blank_n     = r_active;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_pix_en      = r_pix_en;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//
// Directed bench for vga_timing (default build, pixel divider off). Two
// instances share clock and reset: the default 640x480 timing and a small
// 8/2/3/1 x 4/1/1/1 raster whose 98-tick frame makes frame-level behaviour
// reachable in a short run.
// ---------------------------------------------------------------------------
module tb_vga_timing;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [9:0] x, y;
    logic       active, blank_n, hsync, vsync, line_start, frame_start, pix_en;

    logic [9:0] s_x, s_y;
    logic       s_active, s_blank_n, s_hsync, s_vsync, s_line_start, s_frame_start, s_pix_en;

    vga_timing dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .o_x           (x),
        .o_y           (y),
        .o_active      (active),
        .o_blank_n     (blank_n),
        .o_hsync       (hsync),
        .o_vsync       (vsync),
        .o_line_start  (line_start),
        .o_frame_start (frame_start),
        .o_pix_en      (pix_en)
    );

    vga_timing #(
        .H_ACTIVE (8),
        .H_FRONT  (2),
        .H_SYNC   (3),
        .H_BACK   (1),
        .V_ACTIVE (4),
        .V_FRONT  (1),
        .V_SYNC   (1),
        .V_BACK   (1)
    ) dut_s (
        .i_clock       (clk),
        .i_reset       (rst),
        .o_x           (s_x),
        .o_y           (s_y),
        .o_active      (s_active),
        .o_blank_n     (s_blank_n),
        .o_hsync       (s_hsync),
        .o_vsync       (s_vsync),
        .o_line_start  (s_line_start),
        .o_frame_start (s_frame_start),
        .o_pix_en      (s_pix_en)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;

    // Expected raster positions (default and small instance).
    int ex = 799, ey = 524;
    int sx = 13,  sy = 6;

    int tick_no     = 0;
    bit acc_en      = 1'b0;
    int act_line0   = 0;
    int hs_line0    = 0;
    int ls_cnt      = 0;
    int fs_cnt      = 0;
    int vs_s_frame0 = 0;
    int fs_s_cnt    = 0;
    int fs_s_first  = -1;
    int fs_s_second = -1;
    int ls_s_first  = -1;
    int ls_s_second = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One pixel tick: advance both models, wait for the edge, compare all
    // outputs of both instances against the hand-written timing.
    task automatic step();
        logic [31:0] e_act, e_hs, e_vs;
        if (ex == 799) begin ex = 0; ey = (ey == 524) ? 0 : ey + 1; end
        else ex++;
        if (sx == 13) begin sx = 0; sy = (sy == 6) ? 0 : sy + 1; end
        else sx++;

        @(posedge clk);
        #1;
        tick_no++;

        e_act = ((ex < 640) && (ey < 480)) ? 1 : 0;
        e_hs  = ((ex >= 656) && (ex <= 751)) ? 0 : 1;
        e_vs  = ((ey >= 490) && (ey <= 491)) ? 0 : 1;
        chk("x",           x,           ex);
        chk("y",           y,           ey);
        chk("active",      active,      e_act);
        chk("blank_n",     blank_n,     e_act);
        chk("hsync",       hsync,       e_hs);
        chk("vsync",       vsync,       e_vs);
        chk("line_start",  line_start,  (ex == 0) ? 1 : 0);
        chk("frame_start", frame_start, ((ex == 0) && (ey == 0)) ? 1 : 0);
        chk("pix_en",      pix_en,      1);

        e_act = ((sx < 8) && (sy < 4)) ? 1 : 0;
        e_hs  = ((sx >= 10) && (sx <= 12)) ? 0 : 1;
        e_vs  = (sy == 5) ? 0 : 1;
        chk("s_x",           s_x,           sx);
        chk("s_y",           s_y,           sy);
        chk("s_active",      s_active,      e_act);
        chk("s_blank_n",     s_blank_n,     e_act);
        chk("s_hsync",       s_hsync,       e_hs);
        chk("s_vsync",       s_vsync,       e_vs);
        chk("s_line_start",  s_line_start,  (sx == 0) ? 1 : 0);
        chk("s_frame_start", s_frame_start, ((sx == 0) && (sy == 0)) ? 1 : 0);
        chk("s_pix_en",      s_pix_en,      1);

        if (acc_en) begin
            if (ey == 0) begin
                act_line0 += (active === 1'b1) ? 1 : 0;
                hs_line0  += (hsync === 1'b0) ? 1 : 0;
            end
            if (line_start === 1'b1)  ls_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
            if ((tick_no <= 98) && (s_vsync === 1'b0)) vs_s_frame0++;
            if (s_frame_start === 1'b1) begin
                fs_s_cnt++;
                if (fs_s_first < 0) fs_s_first = tick_no;
                else if (fs_s_second < 0) fs_s_second = tick_no;
            end
            if (s_line_start === 1'b1) begin
                if (ls_s_first < 0) ls_s_first = tick_no;
                else if (ls_s_second < 0) ls_s_second = tick_no;
            end
        end
    endtask

    task automatic chk_reset_state(input string phase);
        chk({phase, "_x"},           x,           799);
        chk({phase, "_y"},           y,           524);
        chk({phase, "_active"},      active,      0);
        chk({phase, "_blank_n"},     blank_n,     0);
        chk({phase, "_hsync"},       hsync,       1);
        chk({phase, "_vsync"},       vsync,       1);
        chk({phase, "_line_start"},  line_start,  0);
        chk({phase, "_frame_start"}, frame_start, 0);
        chk({phase, "_pix_en"},      pix_en,      0);
        chk({phase, "_s_x"},         s_x,         13);
        chk({phase, "_s_y"},         s_y,         6);
        chk({phase, "_s_hsync"},     s_hsync,     1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held over a few edges.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");

        // Release: first tick presents (0,0) with both strobes.
        rst    = 1'b0;
        acc_en = 1'b1;
        step();
        chk("first_x",           x,           0);
        chk("first_y",           y,           0);
        chk("first_active",      active,      1);
        chk("first_frame_start", frame_start, 1);
        chk("first_line_start",  line_start,  1);
        chk("first_s_frame",     s_frame_start, 1);

        step();
        chk("second_x",           x,           1);
        chk("second_frame_start", frame_start, 0);
        chk("second_line_start",  line_start,  0);

        // Three full lines of the default raster: 2400 ticks total.
        for (int i = 2; i < 2400; i++) step();
        acc_en = 1'b0;

        chk("line0_active_ticks", act_line0, 640);
        chk("line0_hsync_low",    hs_line0,  96);
        chk("line_start_count",   ls_cnt,    3);
        chk("frame_start_count",  fs_cnt,    1);
        chk("end_x",              x,         799);
        chk("end_y",              y,         2);
        chk("s_vsync_low_frame0", vs_s_frame0, 14);
        chk("s_frame_count",      fs_s_cnt,  25);
        chk("s_frame_period",     fs_s_second - fs_s_first, 98);
        chk("s_line_period",      ls_s_second - ls_s_first, 14);

        // Move to (300,3), then reset asynchronously between edges.
        for (int i = 0; i < 301; i++) step();
        chk("pre_rst_x", x, 300);
        chk("pre_rst_y", y, 3);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("async_rst");

        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst_hold");

        rst = 1'b0;
        ex = 799; ey = 524;
        sx = 13;  sy = 6;
        step();
        chk("rel_x",           x,           0);
        chk("rel_y",           y,           0);
        chk("rel_frame_start", frame_start, 1);
        chk("rel_s_frame",     s_frame_start, 1);
        for (int i = 0; i < 100; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
